// File: rtl/pram_adr_seq.sv
// pram_adr_seq: program-RAM address sequencer with init-load, jump, call and return.
// Define PRAM_ADR_STACK_EN to build the return-address stack; otherwise call/ret degrade to load/inc.
module pram_adr_seq #(
    parameter int ADR_WL      = 12,
    parameter int DATA_WL     = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               a_reset_l,
    input  logic [ADR_WL-1:0]  adr_in,
    input  logic               adr_ld_in,
    input  logic               inc_in,
    input  logic               call_in,
    input  logic               ret_in,
    input  logic               init_mode_in,
    input  logic               init_valid_in,
    input  logic [DATA_WL-1:0] init_data_in,
    output logic               init_rdy_out,
    output logic [ADR_WL-1:0]  adr_out,
    output logic [DATA_WL-1:0] wdata_out,
    output logic               we_out,
    output logic               start_out,
    output logic               ovr_out,
    output logic               stk_err_out
);
    typedef enum logic [1:0] {IDLE, INIT, START, RUN} state_t;
    state_t state, state_nxt;
    logic [ADR_WL-1:0] pc, pc_inc;
    logic ovr, wrap;
    if (STACK_DEPTH < 1) begin : g_bad_depth
        $error("STACK_DEPTH must be at least 1");
    end
    assign pc_inc    = pc + 1'b1;
    assign wrap      = &pc;
    assign adr_out   = pc;
    assign wdata_out = init_data_in;
    assign ovr_out   = ovr;
`ifdef PRAM_ADR_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    logic [ADR_WL-1:0] stack [2**SPW];
    logic [SPW-1:0] sp;
    logic stk_err, stk_full;
    assign stk_full    = sp == SPW'(STACK_DEPTH);
    assign stk_err_out = stk_err;
    // Storage needs no reset: sp alone defines which entries are live.
    always_ff @(posedge clk)
        if (state == RUN && !init_mode_in && !ret_in && call_in && !stk_full) stack[sp] <= pc_inc;
`else
    assign stk_err_out = 1'b0;
`endif
    always_comb begin
        state_nxt    = state;
        init_rdy_out = 1'b0;
        we_out       = 1'b0;
        start_out    = 1'b0;
        case (state)
            IDLE:  state_nxt = init_mode_in ? INIT : START;
            INIT: begin
                init_rdy_out = 1'b1;
                we_out       = init_valid_in;
                state_nxt    = init_mode_in ? INIT : START;
            end
            START: begin
                start_out = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = init_mode_in ? INIT : RUN;
        endcase
    end
    always_ff @(posedge clk or negedge a_reset_l) begin
        if (!a_reset_l) begin
            state <= IDLE;
            pc    <= '0;
            ovr   <= 1'b0;
`ifdef PRAM_ADR_STACK_EN
            sp      <= '0;
            stk_err <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                // The last word offered while leaving INIT is still written, at the old pc.
                if (!init_mode_in) begin
                    pc  <= '0;
                    ovr <= 1'b0;
                end else if (init_valid_in) begin
                    pc  <= pc_inc;
                    ovr <= ovr | wrap;
                end
            end else if (state == RUN) begin
                if (init_mode_in) begin
                    pc  <= '0;
                    ovr <= 1'b0;
`ifdef PRAM_ADR_STACK_EN
                    sp      <= '0;
                    stk_err <= 1'b0;
`endif
                end
`ifdef PRAM_ADR_STACK_EN
                else if (ret_in) begin
                    if (sp == '0) begin
                        pc      <= pc_inc;
                        stk_err <= 1'b1;
                    end else begin
                        pc <= stack[sp - 1'b1];
                        sp <= sp - 1'b1;
                    end
                end else if (call_in) begin
                    pc <= adr_in;
                    if (stk_full) stk_err <= 1'b1;
                    else sp <= sp + 1'b1;
                end else if (adr_ld_in) pc <= adr_in;
`else
                else if (ret_in) begin
                    pc  <= pc_inc;
                    ovr <= ovr | wrap;
                end else if (call_in || adr_ld_in) pc <= adr_in;
`endif
                else if (inc_in) begin
                    pc  <= pc_inc;
                    ovr <= ovr | wrap;
                end
            end
        end
    end
endmodule

// File: doc/pram_adr_seq.md
PRAM_ADR_SEQ -- requirements
Module: pram_adr_seq

Interface
REQ-001 Parameter ADR_WL, default 12, address width in bits.
REQ-002 Parameter DATA_WL, default 16, program word width in bits.
REQ-003 Parameter STACK_DEPTH, default 4, number of return-address stack entries (>=1).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 a_reset_l  in  1  asynchronous, active-low reset.
REQ-006 adr_in  in  ADR_WL  jump/call target.
REQ-007 adr_ld_in  in  1  load pc from adr_in (RUN).
REQ-008 inc_in  in  1  increment pc (RUN).
REQ-009 call_in  in  1  push return address, jump to adr_in (RUN).
REQ-010 ret_in  in  1  pop pc from stack (RUN).
REQ-011 init_mode_in  in  1  level; requests program-load mode.
REQ-012 init_valid_in  in  1  init word valid.
REQ-013 init_data_in  in  DATA_WL  init word.
REQ-014 init_rdy_out  out  1  ready for init word.
REQ-015 adr_out  out  ADR_WL  PRAM address (= pc).
REQ-016 wdata_out  out  DATA_WL  PRAM write data (= init_data_in).
REQ-017 we_out  out  1  PRAM write enable.
REQ-018 start_out  out  1  one-cycle pulse on entering RUN.
REQ-019 ovr_out  out  1  sticky address overflow.
REQ-020 stk_err_out  out  1  sticky stack overflow/underflow.

Function
REQ-021 FSM states IDLE, INIT, START, RUN; one state per cycle minimum.
REQ-022 IDLE: init_mode_in=1 -> INIT, else -> START; pc held at 0.
REQ-023 INIT: init_rdy_out=1; we_out = init_valid_in combinationally; each accepted word written at current pc, pc+1 next cycle.
REQ-024 INIT: write at pc = 2^ADR_WL-1 sets ovr_out; pc wraps to 0.
REQ-025 INIT with init_mode_in=0 sampled -> START, pc<=0, ovr_out cleared; a word presented that cycle is still written.
REQ-026 START: start_out=1 for exactly that cycle, adr_out=0, -> RUN.
REQ-027 RUN priority per cycle: ret_in > call_in > adr_ld_in > inc_in; no request -> pc holds.
REQ-028 RUN inc: pc<=pc+1 modulo 2^ADR_WL; wrap from all-ones sets ovr_out.
REQ-029 RUN adr_ld: pc<=adr_in next cycle (1-cycle latency).
REQ-030 RUN call: push pc+1 (modulo), pc<=adr_in; stack full -> push dropped, jump taken, stk_err_out set.
REQ-031 RUN ret: pc<=top, pop; stack empty -> pc<=pc+1, stk_err_out set.
REQ-032 RUN with init_mode_in=1 -> INIT next cycle, pc<=0, stack emptied, sticky flags cleared; RUN request that cycle ignored.
REQ-033 we_out=0 and init_rdy_out=0 in every state except INIT.

Reset
REQ-034 a_reset_l=0 forces immediately: state IDLE, pc=0, stack empty, all outputs 0 except wdata_out (follows input).
REQ-035 Reset mid-INIT or mid-RUN discards all progress; no write issued while reset asserted.

Configuration
REQ-036 Macro PRAM_ADR_STACK_EN defined: return stack built as REQ-030/031.
REQ-037 Macro undefined: no stack storage; call_in acts as adr_ld_in, ret_in acts as inc_in (same priority slot), stk_err_out tied 0, STACK_DEPTH unused.

Verification
REQ-038 Reset release, init_mode_in=1, 3 valid words 0x1111/0x2222/0x3333 -> we_out 3 cycles at adr 0,1,2.
REQ-039 init_mode_in falls -> start_out one pulse, adr_out=0, then inc_in x5 -> adr_out=5.
REQ-040 RUN pc=0x010, call_in adr_in=0x200 -> adr_out=0x200; ret_in -> adr_out=0x011, stk_err_out=0.
REQ-041 STACK_DEPTH=4, 5 nested calls -> 5th jumps, stk_err_out=1; 5 rets -> 4 pops correct, 5th gives pc+1.
REQ-042 adr_ld_in adr_in=0xFFF then inc_in -> adr_out=0x000, ovr_out=1; simultaneous ret_in+call_in -> ret wins.
REQ-043 a_reset_l pulsed low mid-INIT write burst -> we_out=0 at once, adr_out=0, state IDLE.
